button_pulse_conditioner: RTL and testbench

// - Front end for the DE2 push-buttons: takes the four raw active-low KEY inputs.
// - Synchronises, debounces and edge-detects each key.
// - Emits clean single-cycle active-high pulses for left/right/shoot/stop, plus debounced held levels.
// - Sits directly upstream of inputController, whose inleft/inright/inshoot/instop inputs it drives.

---
 rtl/button_pulse_conditioner_pkg.sv | 9 +
 rtl/button_pulse_conditioner_debounce_channel.sv | 39 +++
 rtl/button_pulse_conditioner.sv | 65 ++++++
 tb/tb_button_pulse_conditioner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/button_pulse_conditioner_pkg.sv
// button_pulse_conditioner_pkg: key indices and default timing for the push-button front end
package button_pulse_conditioner_pkg;
  localparam int KEY_LEFT = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_SHOOT = 2;
  localparam int KEY_STOP = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_CYCLES = 5000000;
endpackage

// File: rtl/button_pulse_conditioner_debounce_channel.sv
// button_pulse_conditioner_debounce_channel: synchronise, debounce and press-detect one active-low key
module button_pulse_conditioner_debounce_channel
  import button_pulse_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic held,
  output logic press
);
  logic r_s1;
  logic r_sync;
  logic r_stable;
  logic r_press;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic w_done;
  assign w_done = r_cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  assign held = r_stable;
  assign press = r_press;
  // two-flop synchroniser feeding a counter that accepts a new level only after it persists
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_sync <= 1'b0;
      r_stable <= 1'b0;
      r_press <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= ~key_n;
      r_sync <= r_s1;
      r_cnt <= (r_sync == r_stable || w_done) ? '0 : r_cnt + 1'b1;
      r_stable <= (r_sync != r_stable && w_done) ? r_sync : r_stable;
      r_press <= r_sync & ~r_stable & w_done;
    end
  end
endmodule

// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner: four debounced keys to arbitrated single-cycle pulses with shoot auto-repeat
module button_pulse_conditioner
  import button_pulse_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH = 20,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int RPT_WIDTH = 23
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       shoot_pulse,
  output logic       stop_pulse,
  output logic [3:0] held
);
  logic [3:0] w_press;
  logic [RPT_WIDTH-1:0] r_rcnt;
  logic w_rep;
  logic w_left;
  logic w_right;
  logic w_shoot;
  logic w_stop;
  for (genvar i = 0; i < 4; i++) begin : g_ch
    button_pulse_conditioner_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH(CNT_WIDTH)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .key_n(key_n[i]),
      .held(held[i]),
      .press(w_press[i])
    );
  end
  assign w_rep = (REPEAT_CYCLES != 0) && held[KEY_SHOOT] && r_rcnt == RPT_WIDTH'(REPEAT_CYCLES - 1);
  // repeat counter restarts on each fresh shoot press and each repeat tick, idles while released
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rcnt <= '0;
    else r_rcnt <= (!held[KEY_SHOOT] || w_press[KEY_SHOOT] || w_rep) ? '0 : r_rcnt + 1'b1;
  end
  // stop overrides steering; simultaneous left and right cancel each other
  always_comb begin
    w_left = w_press[KEY_LEFT] & ~w_press[KEY_RIGHT] & ~w_press[KEY_STOP];
    w_right = w_press[KEY_RIGHT] & ~w_press[KEY_LEFT] & ~w_press[KEY_STOP];
    w_shoot = w_press[KEY_SHOOT] | w_rep;
    w_stop = w_press[KEY_STOP];
  end
  // register the arbitrated pulses so every output leaves a flop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      left_pulse <= 1'b0;
      right_pulse <= 1'b0;
      shoot_pulse <= 1'b0;
      stop_pulse <= 1'b0;
    end else begin
      left_pulse <= w_left;
      right_pulse <= w_right;
      shoot_pulse <= w_shoot;
      stop_pulse <= w_stop;
    end
  end
endmodule

// File: tb/tb_button_pulse_conditioner.sv
// tb_button_pulse_conditioner: vector table, corner sequences and random keys against a reference model
module tb_button_pulse_conditioner;
  localparam int D = 4;
  localparam int R = 10;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic left_pulse, right_pulse, shoot_pulse, stop_pulse;
  logic [3:0] held;
  int checks = 0;
  int errors = 0;
  int cnt_l, cnt_r, cnt_s, cnt_st;

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH(3),
    .REPEAT_CYCLES(R),
    .RPT_WIDTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_n(key_n),
    .left_pulse(left_pulse),
    .right_pulse(right_pulse),
    .shoot_pulse(shoot_pulse),
    .stop_pulse(stop_pulse),
    .held(held)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] key_n;
    int cycles;
    int nl, nr, ns, nst;
    logic [3:0] held;
  } vec_t;
  vec_t vecs[$];

  logic [3:0] rq[$];
  logic [3:0] sq[$];
  logic [3:0] m_held, m_press;
  logic [7:0] m_out;
  int k, pe;
  int lf[4];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    sq.delete();
    m_held = '0;
    m_press = '0;
    m_out = '0;
    k = 0;
    pe = -1000000;
    for (int i = 0; i < 4; i++) lf[i] = 0;
  endtask

  // a level is accepted once the synchronised key has disagreed with the accepted level for the
  // last D edges, all of them after the previous change; repeats land every R edges after a press
  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] sync, np;
    logic rep, all_diff;
    logic [3:0] pulses;
    rep = (R != 0) && m_held[2] && (k > pe) && ((k - pe) % R == 0);
    pulses = {m_press[3], m_press[2] | rep,
              m_press[1] & ~m_press[0] & ~m_press[3],
              m_press[0] & ~m_press[1] & ~m_press[3]};
    k++;
    rq.push_back(raw);
    if (rq.size() > 3) void'(rq.pop_front());
    sync = (rq.size() == 3) ? rq[0] : 4'h0;
    sq.push_back(sync);
    if (sq.size() > D) void'(sq.pop_front());
    np = '0;
    for (int i = 0; i < 4; i++) begin
      all_diff = (sq.size() == D);
      foreach (sq[j]) if (sq[j][i] == m_held[i]) all_diff = 1'b0;
      if (all_diff && k - lf[i] >= D) begin
        m_held[i] = ~m_held[i];
        lf[i] = k;
        np[i] = m_held[i];
      end
    end
    if (np[2]) pe = k;
    m_press = np;
    m_out = {pulses[0], pulses[1], pulses[2], pulses[3], m_held};
  endtask

  task automatic tick();
    logic [3:0] raw;
    raw = ~key_n;
    @(posedge clock);
    if (reset) model_edge(raw);
    else model_reset();
    @(negedge clock);
    check("outputs", {left_pulse, right_pulse, shoot_pulse, stop_pulse, held}, m_out);
    cnt_l += int'(left_pulse);
    cnt_r += int'(right_pulse);
    cnt_s += int'(shoot_pulse);
    cnt_st += int'(stop_pulse);
  endtask

  task automatic clear_counts();
    cnt_l = 0;
    cnt_r = 0;
    cnt_s = 0;
    cnt_st = 0;
  endtask

  initial begin
    vecs.push_back('{4'hF, 3, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'hE, 10, 1, 0, 0, 0, 4'h1});
    vecs.push_back('{4'hF, 10, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'hD, 3, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'hF, 8, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'hD, 1, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'hF, 1, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'hD, 12, 0, 1, 0, 0, 4'h2});
    vecs.push_back('{4'hF, 10, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'hB, 40, 0, 0, 4, 0, 4'h4});
    vecs.push_back('{4'hF, 12, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'h6, 10, 0, 0, 0, 1, 4'h9});
    vecs.push_back('{4'hF, 10, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'hC, 10, 0, 0, 0, 0, 4'h3});
    vecs.push_back('{4'hF, 10, 0, 0, 0, 0, 4'h0});
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_state", {left_pulse, right_pulse, shoot_pulse, stop_pulse, held}, 8'h00);
    reset = 1'b1;
    foreach (vecs[v]) begin
      clear_counts();
      key_n = vecs[v].key_n;
      repeat (vecs[v].cycles) tick();
      check_int($sformatf("vec%0d_left", v), cnt_l, vecs[v].nl);
      check_int($sformatf("vec%0d_right", v), cnt_r, vecs[v].nr);
      check_int($sformatf("vec%0d_shoot", v), cnt_s, vecs[v].ns);
      check_int($sformatf("vec%0d_stop", v), cnt_st, vecs[v].nst);
      check($sformatf("vec%0d_held", v), {4'h0, held}, {4'h0, vecs[v].held});
    end
    clear_counts();
    key_n = 4'h7;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    model_reset();
    check("mid_debounce_rst", {left_pulse, right_pulse, shoot_pulse, stop_pulse, held}, 8'h00);
    repeat (2) tick();
    check_int("no_stop_before_release", cnt_st, 0);
    clear_counts();
    reset = 1'b1;
    repeat (6) tick();
    check_int("stop_not_yet", cnt_st, 0);
    tick();
    check("stop_at_latency7", {7'h0, stop_pulse}, 8'h01);
    repeat (5) tick();
    check_int("stop_after_reset", cnt_st, 1);
    check("stop_held", {4'h0, held}, 8'h08);
    clear_counts();
    key_n = 4'hF;
    repeat (10) tick();
    check_int("release_pulses", cnt_l + cnt_r + cnt_s + cnt_st, 0);
    check("release_held", {4'h0, held}, 8'h00);
    key_n = 4'hE;
    repeat (7) tick();
    check("pulse_before_cut", {7'h0, left_pulse}, 8'h01);
    reset = 1'b0;
    #1;
    model_reset();
    check("pulse_cut", {left_pulse, right_pulse, shoot_pulse, stop_pulse, held}, 8'h00);
    tick();
    key_n = 4'hF;
    reset = 1'b1;
    repeat (10) tick();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) key_n = 4'($urandom);
      tick();
    end
    key_n = 4'hF;
    repeat (20) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
